// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: func3 encodings, FSM states and
// byte-lane helpers.
package dmem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    // Byte enables for an access of 2**size bytes starting at byte offset off.
    function automatic logic [7:0] size_be(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0f;
            default: base = 8'hff;
        endcase
        return base << off;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return off[0];
            2'd2:    return |off[1:0];
            default: return |off;
        endcase
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Extracts the addressed lanes from a 64-bit storage word and sign/zero-extends them
// according to the load func3.
module load_formatter
    import dmem_pkg::*;
(
    input  logic [63:0] word_i,
    input  logic [2:0]  offset_i,
    input  logic [2:0]  func3_i,
    output logic [63:0] data_o
);

    logic [63:0] shifted;

    always_comb begin
        shifted = word_i >> {offset_i, 3'b000};
        data_o  = '0;
        unique case (func3_i)
            LB:      data_o = {{56{shifted[7]}}, shifted[7:0]};
            LH:      data_o = {{48{shifted[15]}}, shifted[15:0]};
            LW:      data_o = {{32{shifted[31]}}, shifted[31:0]};
            LD:      data_o = shifted;
            LBU:     data_o = {56'd0, shifted[7:0]};
            LHU:     data_o = {48'd0, shifted[15:0]};
            LWU:     data_o = {32'd0, shifted[31:0]};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle MEM-stage load/store responder: IDLE -> ACCESS -> RESP, owning a
// byte-enabled 64-bit synchronous RAM and reporting misaligned/illegal accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned XLEN       = 64
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [2:0]      req_func3,
    output logic            req_ready,
    output logic            mem_stall,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int unsigned Words = 2 ** DEPTH_LOG2;

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [2:0]            off_q, off_d;
    logic [2:0]            func3_q, func3_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic                  rsp_valid_q, rsp_valid_d;

    logic [XLEN-1:0]       mem_q [Words];
    logic [XLEN-1:0]       rword_q;
    logic [XLEN-1:0]       wdata_sh;
    logic [XLEN-1:0]       fmt_data;
    logic [7:0]            be;
    logic                  access_err;
    logic                  mem_wr;
    logic                  rd_en;
    logic                  unused_addr;

    assign unused_addr = ^req_addr[XLEN-1:DEPTH_LOG2+3];

    always_comb begin
        if (we_q) begin
            access_err = !(func3_q inside {SB, SH, SW, SD});
        end else begin
            access_err = !(func3_q inside {LB, LH, LW, LD, LBU, LHU, LWU});
        end
        access_err = access_err | misaligned(func3_q[1:0], off_q);
    end

    // Gating with resetn drops a store whose commit edge coincides with reset.
    assign mem_wr   = (state_q == StAccess) && we_q && !access_err && resetn;
    assign rd_en    = (state_q == StAccess) && !we_q;
    assign be       = mem_wr ? size_be(func3_q[1:0], off_q) : 8'h00;
    assign wdata_sh = wdata_q << {off_q, 3'b000};

    always_ff @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (be[b]) begin
                mem_q[idx_q][b*8 +: 8] <= wdata_sh[b*8 +: 8];
            end
        end
        if (rd_en) begin
            rword_q <= mem_q[idx_q];
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        idx_d       = idx_q;
        off_d       = off_q;
        func3_d     = func3_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = StAccess;
                    we_d    = req_we;
                    idx_d   = req_addr[DEPTH_LOG2+2:3];
                    off_d   = req_addr[2:0];
                    func3_d = req_func3;
                    wdata_d = req_wdata;
                end
            end
            StAccess: begin
                state_d     = StResp;
                rsp_valid_d = 1'b1;
                err_d       = access_err;
            end
            StResp: begin
                state_d     = StIdle;
                rsp_valid_d = 1'b0;
                err_d       = 1'b0;
            end
            default: begin
                state_d     = StIdle;
                rsp_valid_d = 1'b0;
                err_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            idx_q       <= '0;
            off_q       <= '0;
            func3_q     <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            idx_q       <= idx_d;
            off_q       <= off_d;
            func3_q     <= func3_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    load_formatter u_load_formatter (
        .word_i   (rword_q),
        .offset_i (off_q),
        .func3_i  (func3_q),
        .data_o   (fmt_data)
    );

    assign req_ready = (state_q == StIdle);
    assign mem_stall = ((state_q == StIdle) && req_valid) || (state_q == StAccess);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = err_q;
    assign rsp_rdata = (rsp_valid_q && !we_q && !err_q) ? fmt_data : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: handshake timing, byte-lane stores, extended loads,
// error cases, reset mid-store, back-to-back requests and address aliasing.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [2:0]  req_func3;
    logic        req_ready;
    logic        mem_stall;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_LOG2 (12),
        .XLEN       (64)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_func3 (req_func3),
        .req_ready (req_ready),
        .mem_stall (mem_stall),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with the DUT idle; leaves at a negedge with the DUT idle again.
    task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] exp_data, input logic exp_err);
        req_valid = 1'b1;
        req_we    = we;
        req_func3 = f3;
        req_addr  = addr;
        req_wdata = wdata;
        #1;
        chk({tag, " idle ready"}, 64'(req_ready), 64'd1);
        chk({tag, " idle stall"}, 64'(mem_stall), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk({tag, " access stall"}, 64'(mem_stall), 64'd1);
        chk({tag, " access ready"}, 64'(req_ready), 64'd0);
        chk({tag, " access rsp_valid"}, 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk({tag, " resp rsp_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, " resp stall"}, 64'(mem_stall), 64'd0);
        chk({tag, " rdata"}, rsp_rdata, exp_data);
        chk({tag, " err"}, 64'(rsp_err), 64'(exp_err));
        @(negedge clk);
        chk({tag, " after rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, " after rdata"}, rsp_rdata, 64'd0);
    endtask

    initial begin
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_func3 = '0;
        repeat (2) @(negedge clk);
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset rdata", rsp_rdata, 64'd0);
        chk("reset err", 64'(rsp_err), 64'd0);
        chk("reset ready", 64'(req_ready), 64'd1);
        chk("reset stall", 64'(mem_stall), 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Doubleword round trip
        txn("sd40", 1'b1, 3'b011, 64'h40, 64'h1122334455667788, 64'd0, 1'b0);
        txn("ld40", 1'b0, 3'b011, 64'h40, 64'd0, 64'h1122334455667788, 1'b0);

        // Byte store into a known word, then signed/unsigned byte and half loads
        txn("sd100", 1'b1, 3'b011, 64'h100, 64'h0123456789ABCDEF, 64'd0, 1'b0);
        txn("sb103", 1'b1, 3'b000, 64'h103, 64'h55555555555555AB, 64'd0, 1'b0);
        txn("ld100", 1'b0, 3'b011, 64'h100, 64'd0, 64'h01234567ABABCDEF, 1'b0);
        txn("lb103", 1'b0, 3'b000, 64'h103, 64'd0, 64'hFFFFFFFFFFFFFFAB, 1'b0);
        txn("lbu103", 1'b0, 3'b100, 64'h103, 64'd0, 64'h00000000000000AB, 1'b0);
        txn("lh102", 1'b0, 3'b001, 64'h102, 64'd0, 64'hFFFFFFFFFFFFABAB, 1'b0);
        txn("lhu106", 1'b0, 3'b101, 64'h106, 64'd0, 64'h0000000000000123, 1'b0);

        // Word store into upper half, word loads
        txn("sd200", 1'b1, 3'b011, 64'h200, 64'hDEADBEEFCAFEF00D, 64'd0, 1'b0);
        txn("sw204", 1'b1, 3'b010, 64'h204, 64'h1234567880000000, 64'd0, 1'b0);
        txn("lw204", 1'b0, 3'b010, 64'h204, 64'd0, 64'hFFFFFFFF80000000, 1'b0);
        txn("lwu204", 1'b0, 3'b110, 64'h204, 64'd0, 64'h0000000080000000, 1'b0);
        txn("ld200", 1'b0, 3'b011, 64'h200, 64'd0, 64'h80000000CAFEF00D, 1'b0);
        txn("lw200", 1'b0, 3'b010, 64'h200, 64'd0, 64'hFFFFFFFFCAFEF00D, 1'b0);

        // Errors: misaligned, illegal func3; storage must be untouched
        txn("lh101 err", 1'b0, 3'b001, 64'h101, 64'd0, 64'd0, 1'b1);
        txn("sw202 err", 1'b1, 3'b010, 64'h202, 64'h11111111, 64'd0, 1'b1);
        txn("ld200 post sw err", 1'b0, 3'b011, 64'h200, 64'd0, 64'h80000000CAFEF00D, 1'b0);
        txn("l111 err", 1'b0, 3'b111, 64'h200, 64'd0, 64'd0, 1'b1);
        txn("s111 err", 1'b1, 3'b111, 64'h200, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1);
        txn("ld204 err", 1'b0, 3'b011, 64'h204, 64'd0, 64'd0, 1'b1);
        txn("ld200 post s111", 1'b0, 3'b011, 64'h200, 64'd0, 64'h80000000CAFEF00D, 1'b0);

        // Reset while a store is in ACCESS: the write must be dropped
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_func3 = 3'b011;
        req_addr  = 64'h40;
        req_wdata = 64'hFFFFFFFFFFFFFFFF;
        @(negedge clk);
        chk("rst mid access stall", 64'(mem_stall), 64'd1);
        resetn    = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst mid rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst mid stall", 64'(mem_stall), 64'd0);
        chk("rst mid ready", 64'(req_ready), 64'd1);
        chk("rst mid err", 64'(rsp_err), 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        txn("ld40 post rst", 1'b0, 3'b011, 64'h40, 64'd0, 64'h1122334455667788, 1'b0);

        // Back-to-back: req_valid held high through RESP, via the aliased address
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_func3 = 3'b011;
        req_addr  = 64'h8040;
        @(negedge clk);
        chk("b2b access rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("b2b resp rsp_valid", 64'(rsp_valid), 64'd1);
        chk("b2b resp ready", 64'(req_ready), 64'd0);
        chk("b2b resp stall", 64'(mem_stall), 64'd0);
        chk("b2b alias rdata", rsp_rdata, 64'h1122334455667788);
        @(negedge clk);
        chk("b2b idle rsp_valid", 64'(rsp_valid), 64'd0);
        chk("b2b idle ready", 64'(req_ready), 64'd1);
        chk("b2b idle stall", 64'(mem_stall), 64'd1);
        req_addr = 64'h200;
        @(negedge clk);
        chk("b2b2 access ready", 64'(req_ready), 64'd0);
        chk("b2b2 access rsp_valid", 64'(rsp_valid), 64'd0);
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b2 resp rsp_valid", 64'(rsp_valid), 64'd1);
        chk("b2b2 rdata", rsp_rdata, 64'h80000000CAFEF00D);
        @(negedge clk);
        chk("b2b2 idle rsp_valid", 64'(rsp_valid), 64'd0);

        // Aliased store lands in the low word
        txn("sd8048", 1'b1, 3'b011, 64'h8048, 64'hA5A5A5A55A5A5A5A, 64'd0, 1'b0);
        txn("ld48", 1'b0, 3'b011, 64'h48, 64'd0, 64'hA5A5A5A55A5A5A5A, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder that serves the CPU pipeline's MEM-stage load/store requests.
- Accepts one request at a time over a valid/ready handshake and drives a stall to hold the pipeline.
- Performs byte-lane writes and sign/zero-extended reads for the RV64 load/store func3 encodings.
- Owns its storage array, a 64-bit-wide synchronous RAM, and flags misaligned or illegal accesses.

Parameters:
- DEPTH_LOG2, 12, log2 of number of 64-bit storage words (4096 words = 32 KiB).
- XLEN, 64, data width; fixed at 64.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  synchronous, active-low reset
- req_valid  input  1  request present (MEM stage holds a load or store)
- req_we  input  1  1 = store, 0 = load
- req_addr  input  64  byte address
- req_wdata  input  64  store data; low bytes used per size
- req_func3  input  3  access size/sign (RV64 load/store func3)
- req_ready  output  1  responder can accept a request this cycle
- mem_stall  output  1  pipeline must hold EX/MEM and earlier stages
- rsp_valid  output  1  response cycle; the pipeline advances at this edge
- rsp_rdata  output  64  formatted load data; 0 for stores and errors
- rsp_err  output  1  misaligned or illegal func3; valid with rsp_valid

Behaviour:
- Reset (resetn=0 sampled at a clk edge):
  - State goes to IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Storage contents are not cleared.
  - Reset mid-transaction abandons the transaction; any write not yet committed is dropped.
- States:
  - IDLE: req_ready=1.
  - ACCESS: performs the storage read or byte-enabled write.
  - RESP: rsp_valid=1.
- Transitions:
  - IDLE to ACCESS when req_valid is high; the request is latched at that edge.
  - ACCESS to RESP unconditionally.
  - RESP to IDLE unconditionally.
- Latency: accept edge to rsp_valid is 2 cycles, for both loads and stores.
- Throughput: one request per 3 cycles.
- mem_stall:
  - mem_stall = (IDLE & req_valid) | ACCESS.
  - mem_stall is 0 in RESP, so the pipeline captures rsp_rdata and advances.
- req_ready=0 in ACCESS and RESP.
  - A req_valid still asserted in RESP is the old request and is ignored.
  - A new request is taken next cycle in IDLE.
- Word index = latched addr[DEPTH_LOG2+2:3]. Higher address bits are ignored (wrap-around). Byte offset = addr[2:0].
- Sizes:
  - func3[1:0]: 00 = byte, 01 = half, 10 = word, 11 = double.
  - Load func3[2]=1 means zero-extend; func3=111 is illegal.
  - Store with func3[2]=1 is illegal.
- Alignment: the offset must be a multiple of the size. Otherwise rsp_err=1, storage is unmodified, and rsp_rdata=0.
- Store: in ACCESS, write req_wdata lanes shifted to the offset. Byte enables cover the size only; other bytes are preserved.
- Load:
  - Storage read is registered in ACCESS.
  - In RESP, extract the lanes at the offset, then sign- or zero-extend to 64 bits.
- rsp_rdata and rsp_err hold their values only in RESP and are 0 otherwise.
- A store followed by a load to the same word returns the new data; writes commit before the later read.

Decomposition:
- Shared package dmem_pkg holds:
  - func3 constants (LB, LH, LW, LD, LBU, LHU, LWU; SB, SH, SW, SD);
  - the state encoding (IDLE, ACCESS, RESP);
  - the size-to-byte-enable function.
- One combinational sub-module, load_formatter: inputs 64-bit word, offset, and func3; output 64-bit extended data.
- The storage array is inferred inline with per-byte write enables.

Test Plan:
- Doubleword round trip: SD 0x1122334455667788 to 0x40, then LD 0x40.
  - rsp_rdata=0x1122334455667788.
  - rsp_valid exactly 2 cycles after each accept.
  - mem_stall high for 2 cycles per request.
- Byte stores and signed/unsigned byte loads:
  - SB 0xAB to 0x103, then LD 0x100: byte 3 = 0xAB, other bytes retain prior values.
  - LB 0x103 = 0xFFFFFFFFFFFFFFAB.
  - LBU 0x103 = 0x00000000000000AB.
- Word loads: SW 0x80000000 to 0x204.
  - LW 0x204 = 0xFFFFFFFF80000000.
  - LWU 0x204 = 0x0000000080000000.
  - LD 0x200: upper half = 0x80000000.
- Errors:
  - LH at 0x101: rsp_err=1, rsp_rdata=0.
  - SW at 0x202: rsp_err=1; LD 0x200 returns the prior content unchanged.
  - func3=111 load: rsp_err=1.
- Reset mid-store: assert resetn=0 while in ACCESS.
  - Next cycle: IDLE, rsp_valid=0, mem_stall=0.
  - The target word keeps its old value; a following LD returns it.
- Back-to-back requests: keep req_valid high through RESP.
  - Only one response is produced.
  - The next request is accepted in the cycle after RESP.
  - Address 0x8000 + 0x40 aliases 0x40 at DEPTH_LOG2=12.
